// File: rtl/sub_bytes_sequencer.sv
// sub_bytes_sequencer
//   Byte-serial front end for the SubBytes datapath. A 128-bit AES state is
//   accepted on a valid/ready handshake and its 16 bytes are issued one per
//   cycle to an external S-box pipeline of fixed latency LAT. The returned
//   bytes are collected back into a 128-bit result, which is then offered on
//   a second valid/ready handshake.
//
//   Ports
//     clk_i, reset_i        clock, asynchronous active-high reset
//     in_valid_i/in_ready_o input handshake, in_state_i byte k = [127-8k -: 8]
//     byte_out_o/valid_o    byte stream to the S-box path (0 when not valid)
//     sub_in_i              substituted byte, LAT cycles after byte_out_o
//     out_valid_o/ready_i   output handshake, out_state_o same byte order

// One result byte. Cleared when a new state is accepted, written once when
// its returned byte arrives.
module sub_bytes_lane (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       we_i,
  input  logic [7:0] d_i,
  output logic [7:0] q_o
);
  logic [7:0] data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)    data_q <= '0;
    else if (clr_i) data_q <= '0;
    else if (we_i)  data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

module sub_bytes_sequencer #(
  parameter int NBYTES = 16,
  parameter int LAT    = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [8*NBYTES-1:0]   in_state_i,
  output logic [7:0]            byte_out_o,
  output logic                  byte_valid_o,
  input  logic [7:0]            sub_in_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [8*NBYTES-1:0]   out_state_o
);
  localparam int IW = $clog2(NBYTES);
  localparam int RW = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [NBYTES-1:0][7:0]   sbuf_q, sbuf_d;
  logic [IW-1:0]            icnt_q, icnt_d;
  logic [RW-1:0]            rcnt_q, rcnt_d;
  logic [LAT:0]             vld_pipe;
  logic                     cap;
  logic                     clr;
  logic [NBYTES-1:0][7:0]   res;

  assign in_ready_o   = (state_q == IDLE);
  assign byte_valid_o = (state_q == ISSUE);
  assign out_valid_o  = (state_q == DONE);

  // vld_pipe[0] is the issue strobe itself; stage LAT lines up with sub_in_i.
  generate
    if (LAT > 0) begin : g_dly
      logic [LAT:1] vld_q;
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) vld_q <= '0;
        else         vld_q <= vld_pipe[LAT-1:0];
      end
      assign vld_pipe = {vld_q, byte_valid_o};
    end else begin : g_nodly
      assign vld_pipe = byte_valid_o;
    end
  endgenerate

  // Gate on state so nothing is written while the result is being offered.
  assign cap = vld_pipe[LAT] & ((state_q == ISSUE) | (state_q == DRAIN));

  always_comb begin
    state_d    = state_q;
    sbuf_d     = sbuf_q;
    icnt_d     = icnt_q;
    rcnt_d     = rcnt_q;
    clr        = 1'b0;
    byte_out_o = '0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sbuf_d  = in_state_i;
          icnt_d  = '0;
          rcnt_d  = '0;
          clr     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // byte 0 sits in the top packed slot
        byte_out_o = sbuf_q[IW'(NBYTES-1) - icnt_q];
        icnt_d     = icnt_q + IW'(1);
        if (icnt_q == IW'(NBYTES-1)) state_d = DRAIN;
      end
      DRAIN: ;
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Last return ends collection; with LAT=0 this happens while still in
    // ISSUE, so it overrides the ISSUE->DRAIN step.
    if (cap) begin
      rcnt_d = rcnt_q + RW'(1);
      if (rcnt_q == RW'(NBYTES-1)) state_d = DONE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      sbuf_q  <= '0;
      icnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sbuf_q  <= sbuf_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  generate
    for (genvar l = 0; l < NBYTES; l++) begin : g_lane
      sub_bytes_lane u_lane (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (clr),
        .we_i    (cap && (rcnt_q == RW'(NBYTES-1-l))),
        .d_i     (sub_in_i),
        .q_o     (res[l])
      );
    end
  endgenerate

  assign out_state_o = res;
endmodule

// File: tb/tb_sub_bytes_sequencer.sv
module tb_sub_bytes_sequencer;
  logic                clk = 1'b0;
  logic                reset;
  logic [2:0]          in_valid, out_ready;
  logic [2:0][127:0]   in_state;
  wire  [2:0]          in_ready, byte_valid, out_valid;
  wire  [2:0][7:0]     byte_out, sub_in;
  wire  [2:0][127:0]   out_state;
  logic [2:0][7:0]     junk;
  logic [7:0]          sbox_t [256];
  int                  cyc = 0;
  int                  n_chk = 0, n_err = 0;

  localparam logic [127:0] VEC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VRES = 128'h638293c31bfc33f5c4eeacea4bc12816;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) junk <= 24'($urandom);

  // instance 0: LAT=0, instance 1: LAT=1, instance 2: LAT=4
  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 4);
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 4);
      sub_bytes_sequencer #(.NBYTES(16), .LAT(L)) u_dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_valid_i   (in_valid[g]),
        .in_ready_o   (in_ready[g]),
        .in_state_i   (in_state[g]),
        .byte_out_o   (byte_out[g]),
        .byte_valid_o (byte_valid[g]),
        .sub_in_i     (sub_in[g]),
        .out_valid_o  (out_valid[g]),
        .out_ready_i  (out_ready[g]),
        .out_state_o  (out_state[g])
      );
      // S-box path model: fixed delay, random junk whenever nothing is due
      if (L == 0) begin : g_l0
        assign sub_in[g] = byte_valid[g] ? sbox_t[byte_out[g]] : junk[g];
      end else begin : g_ln
        logic [7:0] dh [L];
        logic       vh [L];
        always @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int j = 0; j < L; j++) vh[j] <= 1'b0;
          end else begin
            vh[0] <= byte_valid[g];
            dh[0] <= byte_out[g];
            for (int j = 1; j < L; j++) begin
              vh[j] <= vh[j-1];
              dh[j] <= dh[j-1];
            end
          end
        end
        assign sub_in[g] = vh[L-1] ? sbox_t[dh[L-1]] : junk[g];
      end
    end
  endgenerate

  // AES S-box from GF(2^8) inverse and affine map
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    for (int m = 0; m < n; m++) x = {x[6:0], x[7]};
    return x;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int x = 1; x < 256; x++)
      if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_calc(s[127-8*k -: 8]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    while (!in_ready[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready[i], 1);
  endtask

  // Accept st, watch the byte stream, stop at the first out_valid cycle.
  task automatic run(input int i, input logic [127:0] st);
    int t, nb = 0, first = -1, last = -1, tv = -1, zbad = 0;
    logic [127:0] issued = '0;
    wait_ready(i);
    in_valid[i] = 1'b1;
    in_state[i] = st;
    t = cyc;
    @(negedge clk);
    in_valid[i] = 1'b0;
    in_state[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 40; c++) begin
      if (byte_valid[i]) begin
        if (first < 0) first = cyc;
        last   = cyc;
        issued = {issued[119:0], byte_out[i]};
        nb++;
      end else if (byte_out[i] !== 8'h00) zbad++;
      if (out_valid[i]) begin
        tv = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("byte_count", nb, 16);
    chk("first_byte_cycle", first, t + 1);
    chk("last_byte_cycle", last, t + 16);
    chk("issue_seq", issued, st);
    chk("byte_out_idle_zero", zbad, 0);
    chk("out_valid_cycle", tv, t + 17 + lat_of(i));
    chk("result", out_state[i], ref_sub(st));
  endtask

  task automatic accept_out(input int i);
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    chk("ready_after_out_hs", in_ready[i], 1);
    chk("valid_after_out_hs", out_valid[i], 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready[1], 1);
    chk({tag, "_byte_valid"}, byte_valid[1], 0);
    chk({tag, "_byte_out"}, byte_out[1], 0);
    chk({tag, "_out_valid"}, out_valid[1], 0);
    chk({tag, "_out_state"}, out_state[1], 0);
  endtask

  initial begin
    logic [127:0] st, a, b, r0, r2;
    logic [127:0] outs [2];
    int acc [2], ho [2], na, no, nbv0, nbv1, t;

    for (int v = 0; v < 256; v++) sbox_t[v] = sbox_calc(8'(v));
    reset = 1'b1; in_valid = '0; out_ready = '0; in_state = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // all-zero state
    run(1, '0);
    chk("zero_const", out_state[1], {16{8'h63}});
    accept_out(1);

    // reference vector, then hold output while in_valid pulses
    run(1, VEC);
    chk("vec_const", out_state[1], VRES);
    for (int c = 0; c < 5; c++) begin
      in_valid[1] = (c % 2 == 0);
      in_state[1] = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("hold_valid", out_valid[1], 1);
      chk("hold_state", out_state[1], VRES);
      chk("hold_in_ready", in_ready[1], 0);
    end
    in_valid[1] = 1'b0;
    accept_out(1);
    @(negedge clk);
    chk("no_capture_in_done", byte_valid[1], 0);

    // asynchronous reset in the middle of issue
    st = {$urandom, $urandom, $urandom, $urandom};
    wait_ready(1);
    in_valid[1] = 1'b1; in_state[1] = st;
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_byte7", byte_out[1], st[127-56 -: 8]);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b0;
    run(1, {16{8'h01}});
    chk("post_rst_const", out_state[1], {16{8'h7c}});
    accept_out(1);

    // back-to-back with in_valid and out_ready held high
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    in_valid[1] = 1'b1; in_state[1] = a; out_ready[1] = 1'b1;
    na = 0; no = 0; nbv0 = 0; nbv1 = 0;
    acc[0] = -1; acc[1] = -1; ho[0] = -1; ho[1] = -1;
    outs[0] = '0; outs[1] = '0;
    for (int c = 0; c < 80 && no < 2; c++) begin
      if (byte_valid[1]) begin
        if (na < 2) nbv0++; else nbv1++;
      end
      if (in_valid[1] && in_ready[1]) begin acc[na] = cyc; na++; end
      if (out_valid[1] && out_ready[1]) begin outs[no] = out_state[1]; ho[no] = cyc; no++; end
      if (no < 2) begin
        @(negedge clk);
        if (na >= 1) in_state[1] = b;
        if (na >= 2) in_valid[1] = 1'b0;
      end
    end
    @(negedge clk);
    in_valid[1] = 1'b0; out_ready[1] = 1'b0;
    chk("b2b_out0_cycle", ho[0], acc[0] + 18);
    chk("b2b_second_accept", acc[1], ho[0] + 1);
    chk("b2b_out1_cycle", ho[1], acc[1] + 18);
    chk("b2b_res0", outs[0], ref_sub(a));
    chk("b2b_res1", outs[1], ref_sub(b));
    chk("b2b_bytes0", nbv0, 16);
    chk("b2b_bytes1", nbv1, 16);

    // latency sweep on the same vector
    run(0, VEC);
    r0 = out_state[0];
    accept_out(0);
    run(2, VEC);
    r2 = out_state[2];
    accept_out(2);
    chk("sweep_lat0", r0, VRES);
    chk("sweep_match", r2, r0);

    // randomized states across all latencies, random output back-pressure
    for (int r = 0; r < 6; r++) begin
      int i = r % 3;
      int hold = $urandom_range(0, 3);
      st = {$urandom, $urandom, $urandom, $urandom};
      run(i, st);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("rand_hold", out_state[i], ref_sub(st));
      end
      accept_out(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
